ksa32: RTL and testbench
========================

Name: ksa32

Overview:
- 32-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out.
- Computes sum = a + b + cin.
- Combinational prefix core followed by one output register stage.
- Serves as the datapath adder for arithmetic units that need a short, log-depth carry chain.

Parameters:
- None. Width is fixed at 32 bits.

Ports:
- clk   input   1   rising-edge clock for the output register
- rst_n input   1   asynchronous active-low reset; clears output registers
- a     input   32  operand A, unsigned or two's complement
- b     input   32  operand B
- cin   input   1   carry-in
- sum   output  32  registered a+b+cin, bits [31:0]
- cout  output  1   registered carry out of bit 31

Behaviour:
- Reset:
  - rst_n low forces sum=0 and cout=0 immediately (asynchronous), regardless of clk.
  - On deassertion, outputs stay 0 until the first rising clk edge.
- Latency and throughput:
  - Latency is 1 cycle. On each rising clk edge with rst_n high, sum/cout load the result for the a/b/cin values present before that edge.
  - A new operand set is accepted every cycle.
  - No handshake; inputs are sampled unconditionally.
- Pre-processing, per bit i in 0..31:
  - g_i = a_i & b_i
  - p_i = a_i ^ b_i
  - Fold cin into bit 0: G0 = g_0 | (p_0 & cin), P0 = p_0.
- Prefix tree:
  - 5 Kogge-Stone levels at spans 1, 2, 4, 8, 16.
  - At level k, for every bit i >= 2^(k-1): G_i' = G_i | (P_i & G_(i-span)) and P_i' = P_i & P_(i-span).
  - Bits i < span pass through unchanged, using buffer cells.
  - The tree has full fan-out with no sparsity. Only G is required at the last level.
- Post-processing:
  - c_0 = cin
  - c_(i+1) = final group generate G[i:0]
  - sum_i = p_i ^ c_i
  - cout = G[31:0]
- The core is built structurally from generate/propagate, black and grey cells. The behavioural '+' operator is not used anywhere in the core.
- Arithmetic is modulo 2^32; cout is the 33rd bit. Overflow is not flagged; signed overflow detection belongs to the caller.
- Critical path is O(log2 32) = 5 prefix levels plus pre/post XOR, all between the input ports and the output register.
- Reset mid-operation discards the in-flight result; there is no other state.

Test Plan:
- Reset: hold rst_n=0 with a=FFFFFFFF, b=1, cin=1, and toggle clk -> sum=00000000, cout=0 throughout. Assert rst_n asynchronously between edges while outputs are nonzero -> outputs clear without waiting for clk.
- Basic add: a=158A9382, b=70959157, cin=0 -> next edge sum=862024D9, cout=0. Then a=52AF1967, b=9A4E6483, cin=1 -> sum=ECFD7DEB, cout=0.
- Carry-out: a=B9038134, b=C6BD64D1, cin=0 -> sum=7FC0E605, cout=1. Then a=1580000A, b=70950000, cin=1 -> sum=8615000B, cout=0.
- Full ripple through all prefix levels: a=FFFFFFFF, b=00000000, cin=1 -> sum=00000000, cout=1. Then a=FFFFFFFF, b=FFFFFFFF, cin=1 -> sum=FFFFFFFF, cout=1.
- Back-to-back throughput: change a/b/cin every cycle over 1000 random vectors -> each cycle's {cout,sum} equals the 33-bit reference a+b+cin of the previous cycle's inputs, with no bubbles.
- Span boundaries: a=0000FFFF, b=00000001, cin=0 -> sum=00010000. a=7FFFFFFF, b=00000001, cin=0 -> sum=80000000, cout=0. a=00000000, b=00000000, cin=1 -> sum=00000001, cout=0.

Source files
------------

// File: rtl/ksa32.sv
// rtl/ksa32.sv - 32-bit Kogge-Stone prefix adder with carry-in/out and one output register stage
// Structural prefix core (pg, grey, black, buffer cells) feeding a registered sum/cout.

module ksa_pg (
  input  logic a_i,
  input  logic b_i,
  output logic g_o,
  output logic p_o
);
  assign g_o = a_i & b_i;
  assign p_o = a_i ^ b_i;
endmodule

module ksa_grey (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  output logic g_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
endmodule

module ksa_black (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;
endmodule

module ksa_buf (
  input  logic x_i,
  output logic y_o
);
  assign y_o = x_i;
endmodule

module ksa32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g_raw;
  logic [31:0] p_raw;
  // gl[k]/pl[k] hold group generate/propagate after prefix level k; level 0 has cin folded in.
  logic [31:0] gl [0:5];
  logic [31:0] pl [0:4];
  logic [31:0] carry;
  logic [31:0] sum_d, sum_q;
  logic        cout_d, cout_q;

  genvar i, k;
  generate
    for (i = 0; i < 32; i++) begin : g_pre
      ksa_pg u_pg (.a_i(a[i]), .b_i(b[i]), .g_o(g_raw[i]), .p_o(p_raw[i]));
      ksa_buf u_pbuf (.x_i(p_raw[i]), .y_o(pl[0][i]));
      if (i == 0) begin : g_cin
        ksa_grey u_cin (.g_hi_i(g_raw[0]), .p_hi_i(p_raw[0]), .g_lo_i(cin), .g_o(gl[0][0]));
      end else begin : g_pass
        ksa_buf u_gbuf (.x_i(g_raw[i]), .y_o(gl[0][i]));
      end
    end

    for (k = 1; k <= 5; k++) begin : g_lvl
      localparam int SPAN = 1 << (k - 1);
      for (i = 0; i < 32; i++) begin : g_bit
        if (i >= SPAN) begin : g_cell
          // Last level only needs group generate, so it uses grey cells.
          if (k < 5) begin : g_blk
            ksa_black u_blk (
              .g_hi_i(gl[k-1][i]), .p_hi_i(pl[k-1][i]),
              .g_lo_i(gl[k-1][i-SPAN]), .p_lo_i(pl[k-1][i-SPAN]),
              .g_o(gl[k][i]), .p_o(pl[k][i])
            );
          end else begin : g_gry
            ksa_grey u_gry (
              .g_hi_i(gl[k-1][i]), .p_hi_i(pl[k-1][i]),
              .g_lo_i(gl[k-1][i-SPAN]), .g_o(gl[k][i])
            );
          end
        end else begin : g_thru
          ksa_buf u_gb (.x_i(gl[k-1][i]), .y_o(gl[k][i]));
          if (k < 5) begin : g_pb
            ksa_buf u_pb (.x_i(pl[k-1][i]), .y_o(pl[k][i]));
          end
        end
      end
    end
  endgenerate

  assign carry  = {gl[5][30:0], cin};
  assign sum_d  = pl[0] ^ carry;
  assign cout_d = gl[5][31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= 32'h0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_ksa32.sv
// tb/tb_ksa32.sv - directed and random self-checking bench for ksa32
// Inputs change just after each rising edge; outputs are sampled 1 ns after the edge.

module tb_ksa32;
  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        cout;

  int checks = 0;
  int errors = 0;

  ksa32 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] s_exp, input logic c_exp);
    checks++;
    assert ({cout, sum} === {c_exp, s_exp}) else begin
      errors++;
      $error("FAIL %s: got sum=%h cout=%b, expected sum=%h cout=%b", tag, sum, cout, s_exp, c_exp);
    end
  endtask

  task automatic apply(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    a   = av;
    b   = bv;
    cin = cv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] ref_val;
    logic [31:0] ra, rb;
    logic        rc;

    rst_n = 1'b0;
    a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b1;
    #1;
    check("rst_initial", 32'h0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold", 32'h0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_no_edge", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("first_after_reset", 32'h00000001, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(32'h158A9382, 32'h70959157, 1'b0); check("basic0", 32'h862024D9, 1'b0);
    apply(32'h52AF1967, 32'h9A4E6483, 1'b1); check("basic1", 32'hECFD7DEB, 1'b0);
    apply(32'hB9038134, 32'hC6BD64D1, 1'b0); check("cout0",  32'h7FC0E605, 1'b1);
    apply(32'h1580000A, 32'h70950000, 1'b1); check("cout1",  32'h8615000B, 1'b0);
    apply(32'hFFFFFFFF, 32'h00000000, 1'b1); check("ripple0", 32'h00000000, 1'b1);
    apply(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); check("ripple1", 32'hFFFFFFFF, 1'b1);
    apply(32'h0000FFFF, 32'h00000001, 1'b0); check("span16", 32'h00010000, 1'b0);
    apply(32'h7FFFFFFF, 32'h00000001, 1'b0); check("span31", 32'h80000000, 1'b0);
    apply(32'h00000000, 32'h00000000, 1'b1); check("cin_only", 32'h00000001, 1'b0);
    apply(32'h000000FF, 32'h00000001, 1'b0); check("span8", 32'h00000100, 1'b0);
    apply(32'h80000000, 32'h80000000, 1'b0); check("msb_carry", 32'h00000000, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      ref_val = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      apply(ra, rb, rc);
      check("random", ref_val[31:0], ref_val[32]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
